// File: rtl/hc8_dma.sv
// Memory-to-memory byte copier that borrows the HC8 bus: 2 cycles per byte after a GRANT_WAIT+1 cycle request phase.
// No backpressure: start is dropped unless idle; done pulses in the cycle after the last write.
module hc8_dma #(
    parameter int GRANT_WAIT = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [15:0]       src_addr,
    input  logic [15:0]       dst_addr,
    input  logic [7:0]        len,
    output logic              nDMA_REQ,
    output wire logic [15:0]  address_bus,
    inout  wire logic [7:0]   data_bus,
    output wire logic         nRAM_RD,
    output wire logic         nRAM_WR,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt, wait_cnt_nx;
    logic [15:0] src, src_nx;
    logic [15:0] dst, dst_nx;
    logic [7:0]  remaining, remaining_nx;
    logic [7:0]  hold;
    logic        done_nx;

    logic        own;
    logic        rd_phase;
    logic        wr_phase;
    logic [15:0] addr_q;

    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        src_nx       = src;
        dst_nx       = dst;
        remaining_nx = remaining;
        done_nx      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != 8'd0) begin
                        state_nx     = S_WAIT;
                        src_nx       = src_addr;
                        dst_nx       = dst_addr;
                        remaining_nx = len;
                        wait_cnt_nx  = 4'd0;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'(GRANT_WAIT)) begin
                    state_nx = S_READ;
                end else begin
                    wait_cnt_nx = wait_cnt + 4'd1;
                end
            end
            S_READ: begin
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                src_nx       = src + 16'd1;
                dst_nx       = dst + 16'd1;
                remaining_nx = remaining - 8'd1;
                if (remaining == 8'd1) begin
                    state_nx = S_RELEASE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_READ;
                end
            end
            S_RELEASE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so every pin except the strobes comes straight off a register.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            src       <= 16'd0;
            dst       <= 16'd0;
            remaining <= 8'd0;
            hold      <= 8'd0;
            nDMA_REQ  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            own       <= 1'b0;
            rd_phase  <= 1'b0;
            wr_phase  <= 1'b0;
            addr_q    <= 16'd0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            src       <= src_nx;
            dst       <= dst_nx;
            remaining <= remaining_nx;
            if (state == S_READ) begin
                hold <= data_bus;
            end
            nDMA_REQ  <= !(state_nx inside {S_WAIT, S_READ, S_WRITE});
            busy      <= (state_nx inside {S_WAIT, S_READ, S_WRITE});
            done      <= done_nx;
            own       <= (state_nx inside {S_READ, S_WRITE});
            rd_phase  <= (state_nx == S_READ);
            wr_phase  <= (state_nx == S_WRITE);
            addr_q    <= (state_nx == S_WRITE) ? dst_nx : src_nx;
        end
    end

    // Strobes follow clk so they are active only during the low half of the owning cycle.
    assign address_bus = own ? addr_q : 16'hzzzz;
    assign nRAM_RD     = own ? (rd_phase ? clk : 1'b1) : 1'bz;
    assign nRAM_WR     = own ? (wr_phase ? clk : 1'b1) : 1'bz;
    assign data_bus    = wr_phase ? hold : 8'hzz;

endmodule

// File: tb/tb_hc8_dma.sv
// Bench for hc8_dma: RAM and frozen-PC core model on a pulled-up shared bus, random copies checked against a byte-queue model.
module tb_hc8_dma;
    localparam int GW = 1;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_addr = 16'd0;
    logic [15:0] dst_addr = 16'd0;
    logic [7:0]  len = 8'd0;
    logic        nDMA_REQ;
    logic        busy;
    logic        done;
    tri1 [15:0]  address_bus;
    tri1 [7:0]   data_bus;
    tri1         nRAM_RD;
    tri1         nRAM_WR;

    hc8_dma #(.GRANT_WAIT(GW)) dut (
        .clk(clk), .nReset(nReset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .nDMA_REQ(nDMA_REQ),
        .address_bus(address_bus), .data_bus(data_bus), .nRAM_RD(nRAM_RD),
        .nRAM_WR(nRAM_WR), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_dat = 8'd0;
    logic        ram_oe = 1'b0;
    int          cyc = 0;
    int          pc = 0;
    int          own_cnt = 0;
    int          contention = 0;
    logic [15:0] rd_addr [$];
    logic [15:0] wr_addr [$];
    int          rd_cyc [$];
    int          done_cyc [$];
    int          total = 0;
    int          bad = 0;

    assign data_bus = ram_oe ? ram_dat : 8'hzz;

    // Rising edge: cycle count, core PC (halts while bus is requested), RAM releases the bus.
    // Falling edge: observe the strobes in their active half and act as the RAM.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            cyc    <= cyc + 1;
            ram_oe <= 1'b0;
            if (nDMA_REQ) pc <= pc + 1;
        end else begin
            if (nRAM_WR === 1'b0) begin
                if (ram_oe) contention = contention + 1;
                mem[address_bus] = data_bus;
                wr_addr.push_back(address_bus);
                own_cnt = own_cnt + 1;
            end
            if (nRAM_RD === 1'b0) begin
                if (nDMA_REQ !== 1'b0) contention = contention + 1;
                rd_addr.push_back(address_bus);
                rd_cyc.push_back(cyc);
                ram_dat <= mem[address_bus];
                ram_oe  <= 1'b1;
                own_cnt = own_cnt + 1;
            end
            if (done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        rd_addr.delete(); wr_addr.delete(); rd_cyc.delete(); done_cyc.delete();
        own_cnt = 0;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l, output int t);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        logic [7:0] exp [$];
        int t, p0;
        bit ok;
        for (int i = 0; i < int'(l); i++) exp.push_back(mem[16'(s + 16'(i))]);
        clear_log();
        pulse_start(s, d, l, t);
        @(negedge clk); #1;
        total++; if (nDMA_REQ !== 1'b0) begin bad++; $display("FAIL req_low got=%b want=0", nDMA_REQ); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_high got=%b want=1", busy); end
        p0 = pc;
        wait_done(2 * int'(l) + GW + 10, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL xfer_timeout src=%h len=%0d got=no done want=done", s, l);
            return;
        end
        total++; if (done_cyc[0] != t + 1 + GW + 2 * int'(l)) begin bad++; $display("FAIL done_latency got=%0d want=%0d", done_cyc[0] - t, 1 + GW + 2 * int'(l)); end
        total++; if (rd_cyc.size() == 0 || rd_cyc[0] != t + 1 + GW) begin bad++; $display("FAIL first_read got_n=%0d want=%0d", rd_cyc.size(), t + 1 + GW); end
        total++; if (rd_addr.size() != int'(l) || wr_addr.size() != int'(l)) begin bad++; $display("FAIL byte_count got_rd=%0d got_wr=%0d want=%0d", rd_addr.size(), wr_addr.size(), l); end
        total++; if (own_cnt != 2 * int'(l)) begin bad++; $display("FAIL bus_cycles got=%0d want=%0d", own_cnt, 2 * int'(l)); end
        for (int i = 0; i < int'(l) && i < rd_addr.size() && i < wr_addr.size(); i++) begin
            total++; if (rd_addr[i] !== 16'(s + 16'(i))) begin bad++; $display("FAIL rd_addr[%0d] got=%h want=%h", i, rd_addr[i], 16'(s + 16'(i))); end
            total++; if (wr_addr[i] !== 16'(d + 16'(i))) begin bad++; $display("FAIL wr_addr[%0d] got=%h want=%h", i, wr_addr[i], 16'(d + 16'(i))); end
            total++; if (mem[16'(d + 16'(i))] !== exp[i]) begin bad++; $display("FAIL data[%0d] got=%h want=%h", i, mem[16'(d + 16'(i))], exp[i]); end
        end
        total++; if (busy !== 1'b0 || nDMA_REQ !== 1'b1) begin bad++; $display("FAIL release_outputs got busy=%b req=%b want busy=0 req=1", busy, nDMA_REQ); end
        total++; if (pc != p0) begin bad++; $display("FAIL pc_frozen got=%0d want=%0d", pc, p0); end
        @(negedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
        total++; if (pc != p0 + 1) begin bad++; $display("FAIL pc_resume got=%0d want=%0d", pc, p0 + 1); end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (nDMA_REQ !== 1'b1) begin bad++; $display("FAIL rst_req got=%b want=1", nDMA_REQ); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (address_bus !== 16'hFFFF) begin bad++; $display("FAIL rst_addr_float got=%h want=ffff", address_bus); end
        total++; if (nRAM_RD !== 1'b1 || nRAM_WR !== 1'b1) begin bad++; $display("FAIL rst_strobes got=%b%b want=11", nRAM_RD, nRAM_WR); end
        total++; if (data_bus !== 8'hFF) begin bad++; $display("FAIL rst_data_float got=%h want=ff", data_bus); end
        nReset = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_basic_copy();
        mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB; mem[16'h0012] = 8'hCC;
        run_xfer(16'h0010, 16'h0020, 8'd3);
    endtask

    task automatic test_len_zero();
        int t;
        clear_log();
        pulse_start(16'h1234, 16'h4321, 8'd0, t);
        total++; if (nDMA_REQ !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL len0_edge got req=%b busy=%b want req=1 busy=0", nDMA_REQ, busy); end
        @(negedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%b want=1", done); end
        total++; if (busy !== 1'b0 || nDMA_REQ !== 1'b1) begin bad++; $display("FAIL len0_idle got busy=%b req=%b want busy=0 req=1", busy, nDMA_REQ); end
        repeat (4) @(negedge clk); #1;
        total++; if (done_cyc.size() != 1 || own_cnt != 0) begin bad++; $display("FAIL len0_quiet got done=%0d bus=%0d want done=1 bus=0", done_cyc.size(), own_cnt); end
        total++; if (address_bus !== 16'hFFFF) begin bad++; $display("FAIL len0_float got=%h want=ffff", address_bus); end
    endtask

    task automatic test_wrap();
        run_xfer(16'hFFFF, 16'h7FFF, 8'd2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            logic [15:0] s, d;
            logic [7:0]  l;
            s = 16'($urandom);
            d = s + 16'h1000 + 16'($urandom_range(0, 16'h7000));
            l = 8'($urandom_range(1, 9));
            run_xfer(s, d, l);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int t, t2, base;
        bit ok;
        logic [7:0] exp [$];
        for (int i = 0; i < 4; i++) exp.push_back(mem[16'h0100 + 16'(i)]);
        clear_log();
        pulse_start(16'h0100, 16'h0200, 8'd4, t);
        repeat (3) @(negedge clk); #1;
        pulse_start(16'h0300, 16'h0400, 8'd5, t2);
        wait_done(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=no done want=done"); end
        // Request during the RELEASE cycle must also be dropped.
        pulse_start(16'h0500, 16'h0600, 8'd3, t2);
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || nDMA_REQ !== 1'b1) begin bad++; $display("FAIL release_start got busy=%b req=%b want busy=0 req=1", busy, nDMA_REQ); end
        base = cyc;
        repeat (14) @(negedge clk); #1;
        total++; if (own_cnt != 8) begin bad++; $display("FAIL b2b_bus_cycles got=%0d want=8", own_cnt); end
        total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=1", done_cyc.size()); end
        total++; if (rd_addr.size() > 0 && rd_addr[rd_addr.size() - 1] !== 16'h0103) begin bad++; $display("FAIL b2b_last_src got=%h want=0103", rd_addr[rd_addr.size() - 1]); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[16'h0200 + 16'(i)] !== exp[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, mem[16'h0200 + 16'(i)], exp[i]); end
        end
        total++; if (cyc - base != 14) begin bad++; $display("FAIL b2b_cycle_budget got=%0d want=14", cyc - base); end
    endtask

    task automatic test_reset_mid();
        int t;
        logic [7:0] exp0, exp1, old2, old3;
        exp0 = mem[16'h0400]; exp1 = mem[16'h0401];
        old2 = mem[16'h0502]; old3 = mem[16'h0503];
        clear_log();
        pulse_start(16'h0400, 16'h0500, 8'd4, t);
        for (int i = 0; i < 20 && cyc != t + 4 + GW; i++) begin
            @(negedge clk); #1;
        end
        total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL mid_pos got_writes=%0d want=2", wr_addr.size()); end
        nReset = 1'b0;
        @(posedge clk); #1;
        total++; if (nDMA_REQ !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got req=%b busy=%b want req=1 busy=0", nDMA_REQ, busy); end
        total++; if (address_bus !== 16'hFFFF || data_bus !== 8'hFF) begin bad++; $display("FAIL mid_rst_float got addr=%h data=%h want ffff ff", address_bus, data_bus); end
        @(negedge clk); #1;
        nReset = 1'b1;
        repeat (12) @(negedge clk); #1;
        total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_cyc.size()); end
        total++; if (mem[16'h0500] !== exp0 || mem[16'h0501] !== exp1) begin bad++; $display("FAIL mid_written got=%h%h want=%h%h", mem[16'h0500], mem[16'h0501], exp0, exp1); end
        total++; if (mem[16'h0502] !== old2 || mem[16'h0503] !== old3) begin bad++; $display("FAIL mid_untouched got=%h%h want=%h%h", mem[16'h0502], mem[16'h0503], old2, old3); end
        total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL mid_write_count got=%0d want=2", wr_addr.size()); end
    endtask

    task automatic test_no_contention();
        total++; if (contention != 0) begin bad++; $display("FAIL bus_contention got=%0d want=0", contention); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid();
        run_xfer(16'h0010, 16'h0020, 8'd3);
        test_no_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end
endmodule
